shiftreg_fill_ctrl: RTL and testbench
=====================================

# shiftreg_fill_ctrl

Load sequencer for the 6144-bit byte-wide coder/interleaver shift register. Accepts a byte stream of code blocks (1056-bit or 6144-bit), drives the register's shift input, enable and clear, and counts bytes per block. When a block is fully shifted in, it presents a parallel-block-valid handshake to the interleaver read side. Sits between the upstream byte source and the shift register instance.

## Interface
- `BYTES_SMALL`, 132, bytes per 1056-bit block
- `BYTES_LARGE`, 768, bytes per 6144-bit block
- `CNT_W`, 10, byte counter width; must hold `BYTES_LARGE`
- `clk` in 1: single clock; all logic on rising edge
- `aclr` in 1: reset, synchronous, active-high
- `in_data` in 8: stream byte
- `in_valid` in 1: byte present
- `in_sop` in 1: first byte of a block; qualified by `in_valid`
- `in_size` in 1: 0 = 1056-bit block, 1 = 6144-bit block; sampled on accepted sop beat
- `in_ready` out 1: controller can accept a byte
- `sr_shiftin` out 8: byte to register `shiftin`
- `sr_shift_en` out 1: register shifts this edge
- `sr_clr` out 1: one-cycle register clear request
- `blk_valid` out 1: register holds a complete block
- `blk_size` out 1: size of held block; valid while `blk_valid`
- `blk_ready` in 1: consumer has taken the block
- `busy` out 1: state ≠ IDLE
- `err_sop` out 1: one-cycle pulse on a protocol error

## Operation
- Beat accepted = `in_valid & in_ready`. `sr_shiftin = in_data` (combinational). `sr_shift_en` = accepted beat.
- N = `BYTES_SMALL` if the latched size is 0, else `BYTES_LARGE`. Byte counter `cnt` (CNT_W bits) counts accepted beats of the current block.
- IDLE: `in_ready`=1.
  - Accepted beat with `in_sop`: latch `in_size`, set `cnt`=1, go to FILL.
  - Accepted beat without `in_sop`: beat is still shifted (harmless), `err_sop` pulses, stay in IDLE.
- FILL: `in_ready`=1.
  - Accepted non-sop beat: `cnt`+1. If `cnt` was N-1, go to FULL.
  - Accepted sop beat mid-block: abort. `err_sop` pulses, size is re-latched, `cnt`=1, stay in FILL. No clear is needed, because N fresh shifts fully overwrite the q_N window.
- FULL: `in_ready`=0, `blk_valid`=1, `blk_size` = latched size.
  - On `blk_ready`: go to IDLE, or to CLEAR if the feature is compiled in.
- CLEAR (optional): `sr_clr`=1 for exactly one cycle, `in_ready`=0, then go to IDLE.
- 1056-bit block: after 132 shifts the data occupies register bits [6143:5088], which is the q_1056 window. No alignment step.
- `aclr`: state=IDLE, `cnt`=0, size=0. Outputs: `blk_valid`=0, `sr_shift_en`=0, `sr_clr`=0, `err_sop`=0, `busy`=0, `in_ready`=1.
- Reset mid-block: the partial block is discarded. Register contents are not cleared by this block.

## Timing
- Zero-cycle data path: an accepted byte enters the register on the same edge.
- `blk_valid` rises the cycle after the N-th beat is accepted. The register is complete in that same cycle.
- `blk_valid` holds until the `blk_ready` edge and drops the next cycle. `blk_ready` while `blk_valid`=0 is ignored.
- Back-to-back blocks, macro off: 1 idle cycle of `in_ready`=0 per block, plus the cycles spent waiting on `blk_ready`.
- Back-to-back blocks, macro on: 2 idle cycles of `in_ready`=0 per block, plus the cycles spent waiting on `blk_ready`.
- `aclr` has priority over every other input in the same cycle.

## Configuration
- `SHIFTREG_FILL_CTRL_FLUSH_EN`
  - Defined: FULL → CLEAR → IDLE, with a one-cycle `sr_clr` pulse, so the register reads zero between blocks.
  - Undefined: CLEAR state is absent, FULL → IDLE directly, and `sr_clr` is tied 0.

## Structure
- Shared package `shiftreg_pkg` holds:
  - state enum: IDLE, FILL, FULL, CLEAR
  - size encodings: SIZE_1056=0, SIZE_6144=1
  - constants `BYTES_SMALL` and `BYTES_LARGE`
- One sub-module, `byte_counter`: loadable, enabled, with terminal-compare output against the selected N.
- The FSM and handshake logic live in the top level.

## Test plan
- 6144 block: sop with size=1, then 768 contiguous beats with values 0..255 repeating → `blk_valid` rises 1 cycle after the last beat. `blk_size`=1. `in_ready`=0 until `blk_ready`.
- 1056 block: 132 beats, with `in_valid` toggled every other cycle → `blk_valid` rises after the 132nd accepted beat. Register bits [6143:5088] equal the stream, with the first byte lowest.
- Abort: 50 beats of a 6144 block, then a sop with size=0 followed by 131 more beats → one `err_sop` pulse, and `blk_valid` with `blk_size`=0 after 132 beats of the new block.
- Stray beat in IDLE without sop → `err_sop` pulses for 1 cycle, `busy` stays 0.
- `blk_ready` held low for 20 cycles → `blk_valid` and `in_ready`=0 are stable for all 20 cycles. Next block accepted the cycle after IDLE (macro off), or after the `sr_clr` pulse (macro on).
- `aclr` asserted at beat 400 of 768 → next cycle: IDLE, `cnt`=0, `in_ready`=1. A following full block completes normally.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: shared state encoding, block-size codes and block byte lengths for the shift-register load sequencer
package shiftreg_pkg;
  typedef enum logic [1:0] {IDLE, FILL, FULL, CLEAR} state_t;
  localparam logic SIZE_1056 = 1'b0;
  localparam logic SIZE_6144 = 1'b1;
  localparam int BYTES_SMALL = 132;
  localparam int BYTES_LARGE = 768;
  localparam int CNT_W = 10;
endpackage

// File: rtl/shiftreg_fill_ctrl_byte_counter.sv
// byte_counter: per-block byte count (clk, aclr, load, en, size in; last out) with terminal compare at N-1 of the selected block length
module byte_counter #(
  parameter int CNT_W = shiftreg_pkg::CNT_W,
  parameter int N_SMALL = shiftreg_pkg::BYTES_SMALL,
  parameter int N_LARGE = shiftreg_pkg::BYTES_LARGE
) (
  input  logic clk,
  input  logic aclr,
  input  logic load,
  input  logic en,
  input  logic size,
  output logic last
);
  import shiftreg_pkg::*;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (aclr) cnt <= '0;
    else if (load) cnt <= CNT_W'(1);
    else if (en) cnt <= cnt + 1'b1;
  assign last = cnt == CNT_W'(size == SIZE_6144 ? N_LARGE - 1 : N_SMALL - 1);
endmodule

// File: rtl/shiftreg_fill_ctrl.sv
// shiftreg_fill_ctrl: byte-stream load sequencer for the 6144-bit shift register (stream in_*, register sr_*, block handshake blk_*, busy, err_sop); SHIFTREG_FILL_CTRL_FLUSH_EN adds a one-cycle sr_clr between blocks
module shiftreg_fill_ctrl #(
  parameter int BYTES_SMALL = shiftreg_pkg::BYTES_SMALL,
  parameter int BYTES_LARGE = shiftreg_pkg::BYTES_LARGE,
  parameter int CNT_W = shiftreg_pkg::CNT_W
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sop,
  input  logic       in_size,
  output logic       in_ready,
  output logic [7:0] sr_shiftin,
  output logic       sr_shift_en,
  output logic       sr_clr,
  output logic       blk_valid,
  output logic       blk_size,
  input  logic       blk_ready,
  output logic       busy,
  output logic       err_sop
);
  import shiftreg_pkg::*;
  state_t state, nxt;
  logic acc, last;
  assign acc = in_valid & in_ready & ~aclr;
  assign sr_shiftin = in_data;
  assign sr_shift_en = acc;
  byte_counter #(.CNT_W(CNT_W), .N_SMALL(BYTES_SMALL), .N_LARGE(BYTES_LARGE)) u_cnt (
    .clk(clk),
    .aclr(aclr),
    .load(acc & in_sop),
    .en(acc & ~in_sop & (state == FILL)),
    .size(blk_size),
    .last(last)
  );
  always_comb
    case (state)
      IDLE: nxt = acc & in_sop ? FILL : IDLE;
      FILL: nxt = acc & ~in_sop & last ? FULL : FILL;
`ifdef SHIFTREG_FILL_CTRL_FLUSH_EN
      FULL: nxt = blk_ready ? CLEAR : FULL;
`else
      FULL: nxt = blk_ready ? IDLE : FULL;
`endif
      default: nxt = IDLE;
    endcase
  always_ff @(posedge clk)
    if (aclr) begin
      state <= IDLE;
      blk_size <= SIZE_1056;
      in_ready <= 1'b1;
      blk_valid <= 1'b0;
      busy <= 1'b0;
      err_sop <= 1'b0;
    end else begin
      state <= nxt;
      if (acc & in_sop) blk_size <= in_size;
      in_ready <= nxt == IDLE || nxt == FILL;
      blk_valid <= nxt == FULL;
      busy <= nxt != IDLE;
      err_sop <= acc & (in_sop == (state == FILL));
    end
`ifdef SHIFTREG_FILL_CTRL_FLUSH_EN
  always_ff @(posedge clk)
    if (aclr) sr_clr <= 1'b0;
    else sr_clr <= nxt == CLEAR;
`else
  assign sr_clr = 1'b0;
`endif
endmodule

// File: tb/tb_shiftreg_fill_ctrl.sv
// tb_shiftreg_fill_ctrl: randomized directed bench for shiftreg_fill_ctrl against a block-level reference model
module tb_shiftreg_fill_ctrl;
  logic clk = 1'b0;
  logic aclr, in_valid, in_sop, in_size, blk_ready;
  logic [7:0] in_data;
  logic in_ready, sr_shift_en, sr_clr, blk_valid, blk_size, busy, err_sop;
  logic [7:0] sr_shiftin;
  always #5 clk = ~clk;
  shiftreg_fill_ctrl dut (
    .clk(clk), .aclr(aclr), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_size(in_size), .in_ready(in_ready), .sr_shiftin(sr_shiftin), .sr_shift_en(sr_shift_en),
    .sr_clr(sr_clr), .blk_valid(blk_valid), .blk_size(blk_size), .blk_ready(blk_ready),
    .busy(busy), .err_sop(err_sop)
  );
`ifdef SHIFTREG_FILL_CTRL_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif
  int n_chk = 0, n_pass = 0, n_err_obs = 0;
  logic [6143:0] sreg = '0;
  bit m_open, m_full, m_clr, m_err, m_size, m_acc;
  int m_got;
  logic [7:0] q[$];
  function automatic int need(bit s);
    return s ? 768 : 132;
  endfunction
  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, o, e);
  endtask
  task automatic cyc();
    bit rdy;
    @(negedge clk);
    rdy = !m_full && !m_clr;
    m_acc = in_valid && rdy && !aclr;
    chk("shift_en", sr_shift_en, m_acc);
    chk("shiftin", sr_shiftin, in_data);
    if (sr_shift_en) sreg = {sr_shiftin, sreg[6143:8]};
    @(posedge clk);
    if (aclr) begin
      m_open = 0; m_full = 0; m_clr = 0; m_size = 0; m_err = 0; m_got = 0;
    end else begin
      m_err = m_acc && (in_sop == m_open);
      if (m_clr) m_clr = 0;
      else if (m_full) begin
        if (blk_ready) begin m_full = 0; m_clr = FLUSH; end
      end else if (m_acc) begin
        if (in_sop) begin
          m_size = in_size; m_got = 1; m_open = 1; q.delete(); q.push_back(in_data);
        end else if (m_open) begin
          m_got++; q.push_back(in_data);
        end
        if (m_open && m_got == need(m_size)) begin m_open = 0; m_full = 1; end
      end
    end
    #1;
    chk("in_ready", in_ready, !m_full && !m_clr);
    chk("blk_valid", blk_valid, m_full);
    chk("busy", busy, m_open || m_full || m_clr);
    chk("err_sop", err_sop, m_err);
    chk("sr_clr", sr_clr, m_clr);
    if (m_full) chk("blk_size", blk_size, m_size);
    if (err_sop) n_err_obs++;
  endtask
  // mode 0: contiguous, 1: valid every other cycle, 2: random valid and blk_ready
  task automatic send_block(bit size, int nb, int mode, bit pat);
    int k = 0, b = 0;
    while (k < nb && b < 20000) begin
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? 1'(b & 1) : 1'($urandom_range(99) < 70);
      in_sop = k == 0;
      in_size = size;
      in_data = pat ? 8'(k) : 8'($urandom);
      blk_ready = mode == 2 ? 1'($urandom) : 1'b0;
      cyc();
      if (m_acc) k++;
      b++;
    end
    in_valid = 0; in_sop = 0; blk_ready = 0;
    chk("block_budget", k, nb);
  endtask
  task automatic chk_window();
    int bad = -1;
    int nb = q.size();
    for (int i = 0; i < nb; i++)
      if (bad < 0 && sreg[6144 - 8 * nb + 8 * i +: 8] !== q[i]) bad = i;
    chk("window_first_bad", bad, -1);
  endtask
  task automatic drain(int w);
    in_valid = 0; blk_ready = 0;
    repeat (w) cyc();
    blk_ready = 1;
    cyc();
    blk_ready = 0;
    repeat (2) cyc();
  endtask
  initial begin
    int e0;
    aclr = 1; in_valid = 0; in_sop = 0; in_size = 0; in_data = 0; blk_ready = 0;
    repeat (2) begin
      in_valid = 1'($urandom); in_sop = 1'($urandom); in_data = 8'($urandom);
      cyc();
    end
    aclr = 0; in_valid = 0; in_sop = 0;
    chk("cnt_reset", dut.u_cnt.cnt, 0);
    cyc();
    send_block(1, 768, 0, 1);
    cyc();
    chk("blk_size_6144", blk_size, 1);
    chk_window();
    drain(3);
    send_block(0, 132, 1, 0);
    cyc();
    chk_window();
    drain(20);
    e0 = n_err_obs;
    send_block(1, 50, 2, 0);
    send_block(0, 132, 2, 0);
    cyc();
    chk("abort_err_pulses", n_err_obs - e0, 1);
    chk("abort_blk_size", blk_size, 0);
    chk_window();
    drain(1);
    e0 = n_err_obs;
    in_valid = 1; in_sop = 0; in_data = 8'($urandom);
    cyc();
    in_valid = 0;
    repeat (2) cyc();
    chk("stray_err_pulses", n_err_obs - e0, 1);
    send_block(1, 399, 2, 0);
    aclr = 1; in_valid = 1; in_sop = 0; in_data = 8'($urandom);
    cyc();
    aclr = 0; in_valid = 0;
    chk("cnt_after_aclr", dut.u_cnt.cnt, 0);
    cyc();
    send_block(1, 768, 2, 0);
    cyc();
    chk_window();
    drain(0);
    repeat (6) begin
      bit sz = 1'($urandom);
      send_block(sz, need(sz), 2, 0);
      cyc();
      chk_window();
      drain($urandom_range(0, 5));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
